// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-channel TDM receive path.
package tdm_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef enum logic {
        HUNT,
        RUN
    } tdm_state_t;

    typedef logic [1:0] ch_idx_t;

endpackage

// File: rtl/one_to_four_demux.sv
// Decodes a 2-bit channel select plus enable into a one-hot write-enable;
// the structural inverse of the transmit-side 4:1 mux.
module one_to_four_demux
    import tdm_pkg::*;
(
    input  ch_idx_t    sel,
    input  logic       en,
    output logic [3:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_4ch.sv
// Frame-aligned TDM receiver: hunts for frame_sync, routes samples into a
// four-channel shadow and publishes each complete frame with a valid pulse.
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  frame_sync,
    output logic [4*WIDTH-1:0]    out_frame,
    output logic                  out_valid,
    output ch_idx_t               ch_sel,
    output logic                  locked,
    output logic                  sync_err
);

    tdm_state_t       state_q;
    tdm_state_t       state_d;
    ch_idx_t          wr_sel;
    ch_idx_t          ch_sel_d;
    logic             wr_en;
    logic             clear_partial;
    logic             frame_done;
    logic             resync;
    logic [3:0]       we;
    logic [WIDTH-1:0] shadow [NUM_CH];

    one_to_four_demux u_demux (
        .sel (wr_sel),
        .en  (wr_en),
        .we  (we)
    );

    always_comb begin
        state_d       = state_q;
        wr_sel        = ch_sel;
        wr_en         = 1'b0;
        clear_partial = 1'b0;
        frame_done    = 1'b0;
        resync        = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        state_d = RUN;
                        wr_en   = 1'b1;
                        wr_sel  = '0;
                    end
                end
                RUN: begin
                    wr_en = 1'b1;
                    // A marker anywhere but slot 0 restarts the frame at ch0.
                    if (frame_sync && (ch_sel != '0)) begin
                        resync        = 1'b1;
                        clear_partial = 1'b1;
                        wr_sel        = '0;
                    end else if (ch_sel == 2'd3) begin
                        frame_done = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        ch_sel_d = wr_en ? ch_idx_t'(wr_sel + 2'd1) : ch_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HUNT;
            ch_sel    <= '0;
            locked    <= 1'b0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            out_frame <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_sel    <= ch_sel_d;
            locked    <= (state_d == RUN);
            out_valid <= frame_done;
            sync_err  <= resync;
            // ch3 arrives on the closing edge, so it bypasses the shadow here.
            if (frame_done) begin
                out_frame <= {in_data, shadow[2], shadow[1], shadow[0]};
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (we[i]) begin
                    shadow[i] <= in_data;
                end else if (clear_partial && (i != 0)) begin
                    shadow[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch: a WIDTH=1 and a WIDTH=4 instance on one clock.
module tb_tdm_demux_4ch;

    logic        clk;
    logic        reset;

    logic        v1, d1, s1;
    logic [3:0]  out_frame1;
    logic        out_valid1, locked1, sync_err1;
    logic [1:0]  ch_sel1;

    logic        v4, s4;
    logic [3:0]  d4;
    logic [15:0] out_frame4;
    logic        out_valid4, locked4, sync_err4;
    logic [1:0]  ch_sel4;

    int checks;
    int passes;
    int ov_cnt;
    int se_cnt;

    tdm_demux_4ch #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (v1),
        .in_data    (d1),
        .frame_sync (s1),
        .out_frame  (out_frame1),
        .out_valid  (out_valid1),
        .ch_sel     (ch_sel1),
        .locked     (locked1),
        .sync_err   (sync_err1)
    );

    tdm_demux_4ch #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (v4),
        .in_data    (d4),
        .frame_sync (s4),
        .out_frame  (out_frame4),
        .out_valid  (out_valid4),
        .ch_sel     (ch_sel4),
        .locked     (locked4),
        .sync_err   (sync_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step1(input logic v, input logic d, input logic s);
        v1 = v; d1 = d; s1 = s;
        @(posedge clk);
        #1;
        if (out_valid1) ov_cnt++;
        if (sync_err1) se_cnt++;
        v1 = 1'b0; s1 = 1'b0;
    endtask

    task automatic step4(input logic v, input logic [3:0] d, input logic s);
        v4 = v; d4 = d; s4 = s;
        @(posedge clk);
        #1;
        if (out_valid4) ov_cnt++;
        if (sync_err4) se_cnt++;
        v4 = 1'b0; s4 = 1'b0;
    endtask

    task automatic do_reset();
        v1 = 1'b0; d1 = 1'b0; s1 = 1'b0;
        v4 = 1'b0; d4 = '0; s4 = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ov_cnt = 0;
        se_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_frame1 !== 4'h0) $display("FAIL reset_frame1 got=%h exp=0", out_frame1); else passes++;
        checks++; if (locked1 !== 1'b0) $display("FAIL reset_locked1 got=%b exp=0", locked1); else passes++;
        checks++; if (out_valid4 !== 1'b0) $display("FAIL reset_valid4 got=%b exp=0", out_valid4); else passes++;
        checks++; if (ch_sel4 !== 2'd0) $display("FAIL reset_chsel4 got=%0d exp=0", ch_sel4); else passes++;
        checks++; if (sync_err4 !== 1'b0) $display("FAIL reset_syncerr4 got=%b exp=0", sync_err4); else passes++;
    endtask

    task automatic test_lock();
        do_reset();
        step1(1'b1, 1'b1, 1'b1);
        checks++; if (locked1 !== 1'b1) $display("FAIL lock_locked_early got=%b exp=1", locked1); else passes++;
        checks++; if (ch_sel1 !== 2'd1) $display("FAIL lock_chsel got=%0d exp=1", ch_sel1); else passes++;
        step1(1'b1, 1'b0, 1'b0);
        step1(1'b1, 1'b1, 1'b0);
        checks++; if (out_valid1 !== 1'b0) $display("FAIL lock_valid_early got=%b exp=0", out_valid1); else passes++;
        step1(1'b1, 1'b1, 1'b0);
        checks++; if (out_valid1 !== 1'b1) $display("FAIL lock_valid got=%b exp=1", out_valid1); else passes++;
        checks++; if (out_frame1 !== 4'b1101) $display("FAIL lock_frame got=%b exp=1101", out_frame1); else passes++;
        step1(1'b0, 1'b0, 1'b0);
        checks++; if (out_valid1 !== 1'b0) $display("FAIL lock_valid_pulse got=%b exp=0", out_valid1); else passes++;
        checks++; if (out_frame1 !== 4'b1101) $display("FAIL lock_frame_hold got=%b exp=1101", out_frame1); else passes++;
        checks++; if (locked1 !== 1'b1) $display("FAIL lock_locked got=%b exp=1", locked1); else passes++;
    endtask

    task automatic test_pre_sync();
        do_reset();
        step1(1'b1, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b0);
        checks++; if (locked1 !== 1'b0) $display("FAIL presync_locked got=%b exp=0", locked1); else passes++;
        checks++; if (ch_sel1 !== 2'd0) $display("FAIL presync_chsel got=%0d exp=0", ch_sel1); else passes++;
        step1(1'b1, 1'b0, 1'b1);
        step1(1'b1, 1'b0, 1'b0);
        step1(1'b1, 1'b1, 1'b0);
        step1(1'b1, 1'b0, 1'b0);
        step1(1'b0, 1'b0, 1'b0);
        checks++; if (out_frame1 !== 4'b0100) $display("FAIL presync_frame got=%b exp=0100", out_frame1); else passes++;
        checks++; if (ov_cnt !== 1) $display("FAIL presync_pulses got=%0d exp=1", ov_cnt); else passes++;
    endtask

    task automatic test_gaps();
        logic [3:0] smp [4];
        logic [1:0] exp_sel [4];
        smp[0] = 4'hA; smp[1] = 4'hB; smp[2] = 4'hC; smp[3] = 4'hD;
        exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3; exp_sel[3] = 2'd0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step4(1'b1, smp[i], (i == 0));
            checks++; if (ch_sel4 !== exp_sel[i]) $display("FAIL gaps_chsel_valid%0d got=%0d exp=%0d", i, ch_sel4, exp_sel[i]); else passes++;
            if (i == 3) begin
                checks++; if (out_valid4 !== 1'b1) $display("FAIL gaps_valid got=%b exp=1", out_valid4); else passes++;
                checks++; if (out_frame4 !== 16'hDCBA) $display("FAIL gaps_frame got=%h exp=dcba", out_frame4); else passes++;
            end
            step4(1'b0, 4'hF, 1'b1);
            checks++; if (ch_sel4 !== exp_sel[i]) $display("FAIL gaps_chsel_idle%0d got=%0d exp=%0d", i, ch_sel4, exp_sel[i]); else passes++;
        end
        checks++; if (ov_cnt !== 1) $display("FAIL gaps_pulses got=%0d exp=1", ov_cnt); else passes++;
    endtask

    task automatic test_resync();
        do_reset();
        step4(1'b1, 4'h1, 1'b1);
        step4(1'b1, 4'h2, 1'b0);
        step4(1'b1, 4'h5, 1'b1);
        checks++; if (sync_err4 !== 1'b1) $display("FAIL resync_err got=%b exp=1", sync_err4); else passes++;
        checks++; if (ch_sel4 !== 2'd1) $display("FAIL resync_chsel got=%0d exp=1", ch_sel4); else passes++;
        step4(1'b1, 4'h6, 1'b0);
        checks++; if (sync_err4 !== 1'b0) $display("FAIL resync_err_pulse got=%b exp=0", sync_err4); else passes++;
        step4(1'b1, 4'h7, 1'b0);
        step4(1'b1, 4'h8, 1'b0);
        checks++; if (out_valid4 !== 1'b1) $display("FAIL resync_valid got=%b exp=1", out_valid4); else passes++;
        checks++; if (out_frame4 !== 16'h8765) $display("FAIL resync_frame got=%h exp=8765", out_frame4); else passes++;
        step4(1'b0, 4'h0, 1'b0);
        checks++; if (se_cnt !== 1) $display("FAIL resync_err_count got=%0d exp=1", se_cnt); else passes++;
        checks++; if (ov_cnt !== 1) $display("FAIL resync_pulses got=%0d exp=1", ov_cnt); else passes++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step4(1'b1, 4'(i), (i == 0) || (i == 4));
            if (i == 3 || i == 7) begin
                checks++; if (out_valid4 !== 1'b1) $display("FAIL b2b_valid%0d got=%b exp=1", i, out_valid4); else passes++;
                checks++; if (ch_sel4 !== 2'd0) $display("FAIL b2b_wrap%0d got=%0d exp=0", i, ch_sel4); else passes++;
            end else begin
                checks++; if (out_valid4 !== 1'b0) $display("FAIL b2b_novalid%0d got=%b exp=0", i, out_valid4); else passes++;
            end
            if (i == 3) begin
                checks++; if (out_frame4 !== 16'h3210) $display("FAIL b2b_frame0 got=%h exp=3210", out_frame4); else passes++;
            end
            if (i == 7) begin
                checks++; if (out_frame4 !== 16'h7654) $display("FAIL b2b_frame1 got=%h exp=7654", out_frame4); else passes++;
            end
        end
        checks++; if (se_cnt !== 0) $display("FAIL b2b_sync_err got=%0d exp=0", se_cnt); else passes++;
    endtask

    task automatic test_reset_mid();
        step4(1'b1, 4'h9, 1'b1);
        step4(1'b1, 4'hA, 1'b0);
        do_reset();
        checks++; if (out_frame4 !== 16'h0000) $display("FAIL rstmid_frame got=%h exp=0000", out_frame4); else passes++;
        checks++; if (ch_sel4 !== 2'd0) $display("FAIL rstmid_chsel got=%0d exp=0", ch_sel4); else passes++;
        checks++; if (locked4 !== 1'b0) $display("FAIL rstmid_locked got=%b exp=0", locked4); else passes++;
        for (int i = 1; i <= 5; i++) begin
            step4(1'b1, 4'(i), 1'b0);
        end
        checks++; if (ov_cnt !== 0) $display("FAIL rstmid_drop_pulses got=%0d exp=0", ov_cnt); else passes++;
        checks++; if (ch_sel4 !== 2'd0) $display("FAIL rstmid_drop_chsel got=%0d exp=0", ch_sel4); else passes++;
        checks++; if (locked4 !== 1'b0) $display("FAIL rstmid_drop_locked got=%b exp=0", locked4); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        ov_cnt = 0;
        se_cnt = 0;
        reset  = 1'b1;
        v1 = 1'b0; d1 = 1'b0; s1 = 1'b0;
        v4 = 1'b0; d4 = '0; s4 = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_lock();
        test_pre_sync();
        test_gaps();
        test_resync();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
